// File: rtl/mac_job_sched.sv
// Round-robin scheduler sharing one pipelined W x W multiply-accumulate datapath
// among NREQ requesters; returns a tagged 2W-bit dot product per job.
module mac_job_sched #(
  parameter int NREQ = 4,
  parameter int W    = 64,
  parameter int LENW = 16,
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*LENW-1:0] len,
  output logic [NREQ-1:0]      grant,
  input  logic                 op_valid,
  input  logic [W-1:0]         op_a,
  input  logic [W-1:0]         op_b,
  output logic                 op_ready,
  output logic                 res_valid,
  output logic [IDW-1:0]       res_id,
  output logic [2*W-1:0]       res_data,
  output logic                 busy
);

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;

  state_t          st;
  logic [LENW-1:0] cnt;
  logic [2*W-1:0]  acc, p, prod, acc_nxt;
  logic            pv, accept;
  logic [IDW-1:0]  last, sel_idx;
  logic            sel_found;
  logic [LENW-1:0] sel_len;
  int              k;

  // First set request strictly after the last granted index, wrapping.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    k         = 0;
    for (int i = 1; i <= NREQ; i++) begin
      k = (int'(last) + i) % NREQ;
      if (!sel_found && req[k]) begin
        sel_found = 1'b1;
        sel_idx   = IDW'(k);
      end
    end
  end

  assign sel_len = len[int'(sel_idx)*LENW +: LENW];
  assign prod    = {{W{1'b0}}, op_a} * {{W{1'b0}}, op_b};
  assign accept  = (st == STREAM) && op_valid && op_ready;
  // Accumulate stage trails the multiply stage by one cycle.
  assign acc_nxt = pv ? acc + p : acc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st        <= IDLE;
      cnt       <= '0;
      acc       <= '0;
      p         <= '0;
      pv        <= 1'b0;
      last      <= IDW'(NREQ - 1);
      grant     <= '0;
      op_ready  <= 1'b0;
      res_valid <= 1'b0;
      res_id    <= '0;
      res_data  <= '0;
      busy      <= 1'b0;
    end else begin
      res_valid <= 1'b0;
      case (st)
        IDLE: begin
          if (sel_found) begin
            cnt  <= sel_len;
            acc  <= '0;
            p    <= '0;
            pv   <= 1'b0;
            last <= sel_idx;
            busy <= 1'b1;
            if (sel_len == '0) begin
              st <= DRAIN;
            end else begin
              st       <= STREAM;
              grant    <= NREQ'(1) << sel_idx;
              op_ready <= 1'b1;
            end
          end
        end
        STREAM: begin
          acc <= acc_nxt;
          pv  <= accept;
          if (accept) begin
            p   <= prod;
            cnt <= cnt - 1'b1;
            if (cnt == LENW'(1)) begin
              st       <= DRAIN;
              grant    <= '0;
              op_ready <= 1'b0;
            end
          end
        end
        DRAIN: begin
          acc       <= acc_nxt;
          pv        <= 1'b0;
          res_data  <= acc_nxt;
          res_id    <= last;
          res_valid <= 1'b1;
          st        <= DONE;
        end
        DONE: begin
          busy <= 1'b0;
          st   <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule
